sha256_block_ctrl: RTL and testbench

// - Sequences one SHA-256 compression per accepted 512-bit block: loads the message schedule,

---
 rtl/sha256_pkg.sv | 81 ++++++++
 rtl/sha256_block_ctrl_if.sv | 23 ++
 rtl/sha256_chain_add.sv | 15 +
 rtl/sha256_block_ctrl.sv | 121 ++++++++++++
 tb/tb_sha256_block_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and bit-mixing functions used by the block controller.
package sha256_pkg;

    localparam int WSIZE = 32;
    localparam int BLK_W = 512;
    localparam int DIG_W = 256;

    typedef logic [31:0]       word_t;
    // Ascending packed ranges: element 0 sits in the most significant bits (a / H0 / word 0).
    typedef logic [0:7][31:0]  work_t;
    typedef logic [0:15][31:0] msg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL
    } state_t;

    localparam work_t H_INIT = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t choose(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t majority(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic work_t round_step(input work_t v, input word_t k, input word_t w);
        word_t t1;
        word_t t2;
        work_t n;
        t1   = v[7] + big_sigma1(v[4]) + choose(v[4], v[5], v[6]) + k + w;
        t2   = big_sigma0(v[0]) + majority(v[0], v[1], v[2]);
        n[0] = t1 + t2;
        n[1] = v[0];
        n[2] = v[1];
        n[3] = v[2];
        n[4] = v[3] + t1;
        n[5] = v[4];
        n[6] = v[5];
        n[7] = v[6];
        return n;
    endfunction

endpackage

// File: rtl/sha256_block_ctrl_if.sv
// Block-source / digest-consumer bundle of the SHA-256 block controller.
interface sha256_block_ctrl_if;
    import sha256_pkg::*;

    logic             blk_valid;
    logic             blk_ready;
    logic [BLK_W-1:0] blk_data;
    logic             blk_first;
    logic [DIG_W-1:0] digest;
    logic             digest_valid;
    logic             busy;
    logic [5:0]       round_idx;

    modport master (
        output blk_valid, blk_data, blk_first,
        input  blk_ready, digest, digest_valid, busy, round_idx
    );

    modport slave (
        input  blk_valid, blk_data, blk_first,
        output blk_ready, digest, digest_valid, busy, round_idx
    );
endinterface

// File: rtl/sha256_chain_add.sv
// Lane-wise mod-2^32 sum of the block's base hash and the final working variables.
module sha256_chain_add
    import sha256_pkg::*;
(
    input  work_t base,
    input  work_t work,
    output work_t sum
);
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            sum[i] = base[i] + work[i];
        end
    end
endmodule

// File: rtl/sha256_block_ctrl.sv
// Sequences one SHA-256 compression per accepted 512-bit block and keeps the chaining value.
module sha256_block_ctrl #(
    parameter int WSIZE  = 32,
    parameter int ROUNDS = 64
) (
    input logic clk,
    input logic rst,
    sha256_block_ctrl_if.slave bus
);
    import sha256_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic             ready_c;
    logic             busy_c;
    logic             load_en;
    logic             round_en;
    logic             final_en;
    logic             last_round;
    logic [5:0]       rcnt;
    msg_t             blk_q;
    logic             first_q;
    work_t            chain_q;
    work_t            base_q;
    work_t            work_q;
    work_t            base_sel;
    work_t            sum;
    logic [WSIZE-1:0] sched [16];
    logic [DIG_W-1:0] digest_q;
    logic             dv_q;

    assign last_round = (rcnt == 6'(ROUNDS - 1));
    // blk_first=0 after reset still sees H_INIT because chain_q resets to it.
    assign base_sel   = first_q ? H_INIT : chain_q;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        busy_c    = 1'b0;
        load_en   = 1'b0;
        round_en  = 1'b0;
        final_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (bus.blk_valid) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                busy_c    = 1'b1;
                load_en   = 1'b1;
                state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                busy_c   = 1'b1;
                round_en = 1'b1;
                if (last_round) state_nxt = ST_FINAL;
            end
            ST_FINAL: begin
                busy_c    = 1'b1;
                final_en  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt     <= '0;
            blk_q    <= '0;
            first_q  <= 1'b0;
            chain_q  <= H_INIT;
            base_q   <= '0;
            work_q   <= '0;
            digest_q <= '0;
            dv_q     <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) sched[i] <= '0;
        end else begin
            dv_q <= 1'b0;
            if (ready_c && bus.blk_valid) begin
                blk_q   <= bus.blk_data;
                first_q <= bus.blk_first;
            end
            if (load_en) begin
                base_q <= base_sel;
                work_q <= base_sel;
                rcnt   <= '0;
                for (int unsigned i = 0; i < 16; i++) sched[i] <= blk_q[i];
            end
            if (round_en) begin
                // sched[0] is W[r]; the window slides one word per round.
                work_q <= round_step(work_q, K_TAB[rcnt], sched[0]);
                rcnt   <= rcnt + 6'd1;
                for (int unsigned i = 0; i < 15; i++) sched[i] <= sched[i + 1];
                sched[15] <= small_sigma1(sched[14]) + sched[9] + small_sigma0(sched[1]) + sched[0];
            end
            if (final_en) begin
                chain_q  <= sum;
                digest_q <= sum;
                dv_q     <= 1'b1;
            end
        end
    end

    sha256_chain_add u_chain_add (
        .base (base_q),
        .work (work_q),
        .sum  (sum)
    );

    assign bus.blk_ready    = ready_c;
    assign bus.busy         = busy_c;
    assign bus.round_idx    = round_en ? rcnt : '0;
    assign bus.digest       = digest_q;
    assign bus.digest_valid = dv_q;
endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Randomised and directed bench for sha256_block_ctrl against a cycle-level SHA-256 model.
module tb_sha256_block_ctrl;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] TK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'b0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'b0};
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    sha256_block_ctrl_if bus ();

    sha256_block_ctrl #(.WSIZE(32), .ROUNDS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight textbook compression of one block on top of hash state h.
    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = h[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[i] + w[i];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Model: k = cycles since the accept edge (0 idle, 1 load, 2..65 rounds, 66 final, 67 digest pulse).
    bit           model_on = 1'b0;
    int           k = 0;
    logic [255:0] mchain, mdig, mexp;

    always @(negedge clk) begin
        if (model_on) begin
            chk("blk_ready",    256'(bus.blk_ready),    256'(k == 0 || k == 67));
            chk("busy",         256'(bus.busy),         256'(k >= 1 && k <= 66));
            chk("digest_valid", 256'(bus.digest_valid), 256'(k == 67));
            chk("round_idx",    256'(bus.round_idx),    256'((k >= 2 && k <= 65) ? k - 2 : 0));
            chk("digest",       bus.digest,             mdig);
        end
        if (rst) begin
            model_on = 1'b1;
            k        = 0;
            mchain   = IV;
            mdig     = '0;
        end else if (model_on) begin
            if (k >= 1 && k <= 65) begin
                k++;
            end else if (k == 66) begin
                k      = 67;
                mchain = mexp;
                mdig   = mexp;
            end else if (bus.blk_valid) begin
                k    = 1;
                mexp = compress(bus.blk_first ? IV : mchain, bus.blk_data);
            end else begin
                k = 0;
            end
        end
    end

    task automatic send(input logic [511:0] d, input logic f, input bit hold, output bit dv_at_acc);
        bit acc = 1'b0;
        int n   = 0;
        dv_at_acc     = 1'b0;
        bus.blk_data  = d;
        bus.blk_first = f;
        bus.blk_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.blk_ready) begin
                acc       = 1'b1;
                dv_at_acc = bus.digest_valid;
            end
        end
        chk("accept", 256'(acc), 256'(1));
        @(posedge clk); #1;
        if (!hold) begin
            bus.blk_valid = 1'b0;
            bus.blk_data  = rand512();
            bus.blk_first = 1'($urandom);
        end
    endtask

    task automatic wait_digest(input bit noise, output logic [255:0] dig);
        int cnt  = 0;
        bit seen = 1'b0;
        dig = '0;
        while (!seen && cnt < 100) begin
            if (noise) begin
                if (cnt < 60) begin
                    bus.blk_valid = 1'($urandom);
                    bus.blk_data  = rand512();
                end else begin
                    bus.blk_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
            cnt++;
            if (bus.digest_valid) begin
                seen = 1'b1;
                dig  = bus.digest;
            end
        end
        chk("latency", 256'(cnt), 256'(66));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] got;
        logic [511:0] b1, b2;
        bit           dv;
        int           n;
        bit           found;
        string        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

        rst           = 1'b1;
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.blk_first = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_digest", bus.digest, '0);
        chk("reset_ready",  256'(bus.blk_ready), 256'(1));

        chk("model_abc",   compress(IV, BLK_ABC),   DIG_ABC);
        chk("model_empty", compress(IV, BLK_EMPTY), DIG_EMPTY);

        send(BLK_ABC, 1'b1, 1'b0, dv);
        wait_digest(1'b0, got);
        chk("abc", got, DIG_ABC);

        send(BLK_EMPTY, 1'b1, 1'b0, dv);
        wait_digest(1'b0, got);
        chk("empty", got, DIG_EMPTY);

        b1 = '0;
        for (int i = 0; i < 56; i++) b1[511 - 8*i -: 8] = s[i];
        b1[511 - 8*56 -: 8] = 8'h80;
        b2 = {480'b0, 32'h000001c0};
        send(b1, 1'b1, 1'b0, dv);
        wait_digest(1'b0, got);
        send(b2, 1'b0, 1'b0, dv);
        wait_digest(1'b0, got);
        chk("two_block", got, DIG_TWO);

        // Back-to-back with blk_valid held high across the whole first block.
        send(BLK_ABC, 1'b1, 1'b1, dv);
        send(BLK_ABC, 1'b1, 1'b0, dv);
        chk("reaccept_with_dv", 256'(dv), 256'(1));
        chk("hold_digest1", bus.digest, DIG_ABC);
        wait_digest(1'b0, got);
        chk("hold_digest2", got, DIG_ABC);

        // Reset in the middle of a block, then chain with blk_first=0.
        send(BLK_EMPTY, 1'b1, 1'b0, dv);
        found = 1'b0;
        n     = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.busy && bus.round_idx == 6'd30) found = 1'b1;
        end
        chk("reach_round30", 256'(found), 256'(1));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst_digest", bus.digest, '0);
        chk("midrst_busy",   256'(bus.busy), 256'(0));
        repeat (80) @(posedge clk);
        #1;
        send(BLK_ABC, 1'b0, 1'b0, dv);
        wait_digest(1'b0, got);
        chk("abc_after_rst", got, DIG_ABC);

        for (int it = 0; it < 10; it++) begin
            send(rand512(), (it == 0) ? 1'b1 : 1'($urandom), 1'b0, dv);
            wait_digest(1'b1, got);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
